// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: collects A then B, one element per beat, row-major,
// into flattened operand buses for the flat-bus matrix multiplier. The
// operands and size are held stable until the consumer acknowledges them.
module matrix_stream_loader #(
    parameter int MAX_SIZE   = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [31:0]                            matrix_size,
    input  logic                                   in_valid,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    output logic                                   in_ready,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] A,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] B,
    output logic [31:0]                            size_out,
    output logic                                   mats_valid,
    input  logic                                   mats_ack,
    output logic                                   busy,
    output logic                                   size_err
);

    localparam int CNT_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   row, col;
    logic               size_legal;
    logic               start_ok;
    logic               start_bad;
    logic               accept;
    logic               last_col;
    logic               last_elem;
    int                 wr_off;

    // Full 32-bit range check so large sizes cannot alias into the legal range.
    assign size_legal = (matrix_size >= 32'd1) && (matrix_size <= 32'(MAX_SIZE));
    assign start_ok   = (state == IDLE) && start && size_legal;
    assign start_bad  = (state == IDLE) && start && !size_legal;
    assign accept     = in_valid && in_ready;
    assign last_col   = (32'(col) == (size_out - 32'd1));
    assign last_elem  = last_col && (32'(row) == (size_out - 32'd1));
    assign wr_off     = (int'(row) * MAX_SIZE + int'(col)) * DATA_WIDTH;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded handshake/status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mats_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) begin
                    state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (accept && last_elem) begin
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (accept && last_elem) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                mats_valid = 1'b1;
                if (mats_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Row/column position of the next element; restarts for each matrix.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_elem ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    // Operand buses and size: cleared on a legal start so unused positions read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            A        <= '0;
            B        <= '0;
            size_out <= '0;
        end else if (start_ok) begin
            A        <= '0;
            B        <= '0;
            size_out <= matrix_size;
        end else if (accept) begin
            if (state == LOAD_A) begin
                A[wr_off +: DATA_WIDTH] <= in_data;
            end else begin
                B[wr_off +: DATA_WIDTH] <= in_data;
            end
        end
    end

    // One-cycle pulse flagging a start request with an unsupported size.
    always_ff @(posedge clk) begin
        if (rst) begin
            size_err <= 1'b0;
        end else begin
            size_err <= start_bad;
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed testbench for matrix_stream_loader.
module tb_matrix_stream_loader;

    localparam int MS = 10;
    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [31:0]           matrix_size = '0;
    logic                  in_valid = 1'b0;
    logic [DW-1:0]         in_data = '0;
    logic                  in_ready;
    logic [MS*MS*DW-1:0]   A;
    logic [MS*MS*DW-1:0]   B;
    logic [31:0]           size_out;
    logic                  mats_valid;
    logic                  mats_ack = 1'b0;
    logic                  busy;
    logic                  size_err;

    int checks = 0;
    int errors = 0;

    matrix_stream_loader #(.MAX_SIZE(MS), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .A(A), .B(B), .size_out(size_out), .mats_valid(mats_valid),
        .mats_ack(mats_ack), .busy(busy), .size_err(size_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] a_el(input int r, input int c);
        return A[(r*MS+c)*DW +: DW];
    endfunction

    function automatic logic [31:0] b_el(input int r, input int c);
        return B[(r*MS+c)*DW +: DW];
    endfunction

    // Compare every position of A and B against row-major ramps starting at
    // base_a / base_b inside the n x n region and zero outside it.
    task automatic check_mats(input string tag, input int n, input int base_a, input int base_b);
        int bad = 0;
        for (int r = 0; r < MS; r++) begin
            for (int c = 0; c < MS; c++) begin
                logic [31:0] ea, eb;
                ea = (r < n && c < n) ? 32'(base_a + r*n + c) : 32'd0;
                eb = (r < n && c < n) ? 32'(base_b + r*n + c) : 32'd0;
                if (a_el(r, c) !== ea) bad++;
                if (b_el(r, c) !== eb) bad++;
            end
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic do_start(input logic [31:0] n);
        @(negedge clk);
        start = 1'b1;
        matrix_size = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams count ramp values starting at first; toggle inserts a gap every other cycle.
    task automatic stream(input int first, input int count, input bit toggle);
        int k = 0;
        int guard = 0;
        bit phase = 1'b1;
        bit acc;
        while (k < count && guard < 2000) begin
            in_valid = toggle ? phase : 1'b1;
            in_data  = 32'(first + k);
            acc = in_valid && in_ready;
            if (acc && k == count - 1) check("mv_low_before_last", 32'(mats_valid), 32'd0);
            @(negedge clk);
            if (acc) k++;
            phase = ~phase;
            guard++;
        end
        in_valid = 1'b0;
        if (k != count) check("stream_timeout", 32'(k), 32'(count));
    endtask

    task automatic ack();
        @(negedge clk);
        mats_ack = 1'b1;
        @(negedge clk);
        mats_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mats_valid", 32'(mats_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_size_err", 32'(size_err), 0);
        check("rst_size_out", size_out, 0);
        check("rst_A", 32'(|A), 0);
        check("rst_B", 32'(|B), 0);

        // n=2 basic load
        do_start(2);
        check("t1_busy", 32'(busy), 1);
        check("t1_in_ready", 32'(in_ready), 1);
        check("t1_size_out", size_out, 2);
        stream(1, 8, 1'b0);
        check("t1_mats_valid", 32'(mats_valid), 1);
        check("t1_in_ready_hold", 32'(in_ready), 0);
        check("t1_A00", a_el(0, 0), 1);
        check("t1_A01", a_el(0, 1), 2);
        check("t1_A10", a_el(1, 0), 3);
        check("t1_A11", a_el(1, 1), 4);
        check("t1_B11", b_el(1, 1), 8);
        check_mats("t1_all", 2, 1, 5);
        ack();
        check("t1_mv_after_ack", 32'(mats_valid), 0);
        check("t1_busy_after_ack", 32'(busy), 0);
        check_mats("t1_retained", 2, 1, 5);

        // n=MAX_SIZE with gapped valid
        do_start(MS);
        stream(0, 200, 1'b1);
        check("t2_mats_valid", 32'(mats_valid), 1);
        check("t2_A99", a_el(9, 9), 99);
        check("t2_B00", b_el(0, 0), 100);
        check("t2_B99", b_el(9, 9), 199);
        check_mats("t2_all", MS, 0, 100);
        for (int i = 0; i < 3; i++) begin
            check("t2_in_ready_hold", 32'(in_ready), 0);
            @(negedge clk);
        end
        ack();

        // n=3 load, then n=1 must clear everything else
        do_start(3);
        stream(11, 18, 1'b0);
        check_mats("t3_n3", 3, 11, 20);
        ack();
        do_start(1);
        stream(7, 2, 1'b0);
        check("t3_A00", a_el(0, 0), 7);
        check("t3_B00", b_el(0, 0), 8);
        check_mats("t3_n1", 1, 7, 8);
        ack();

        // Illegal sizes
        begin
            logic [31:0] bad_sizes [3];
            bad_sizes[0] = 32'd0;
            bad_sizes[1] = 32'd11;
            bad_sizes[2] = 32'h0000_0102;
            for (int i = 0; i < 3; i++) begin
                do_start(bad_sizes[i]);
                check("t4_size_err_pulse", 32'(size_err), 1);
                check("t4_busy", 32'(busy), 0);
                @(negedge clk);
                check("t4_size_err_drop", 32'(size_err), 0);
                check("t4_size_out", size_out, 1);
                check_mats("t4_mats", 1, 7, 8);
            end
        end

        // Reset mid-load
        do_start(2);
        stream(1, 3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_in_ready", 32'(in_ready), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_A_zero", 32'(|A), 0);
        check("t5_size_out", size_out, 0);
        do_start(2);
        stream(21, 8, 1'b0);
        check("t5_mats_valid", 32'(mats_valid), 1);
        check_mats("t5_reload", 2, 21, 25);

        // start in HOLD and in the ack cycle is ignored
        do_start(3);
        check("t6_busy_hold", 32'(busy), 1);
        check("t6_mv_hold", 32'(mats_valid), 1);
        check("t6_size_hold", size_out, 2);
        check_mats("t6_stable", 2, 21, 25);
        @(negedge clk);
        mats_ack = 1'b1;
        start = 1'b1;
        matrix_size = 32'd3;
        @(negedge clk);
        mats_ack = 1'b0;
        start = 1'b0;
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_mv", 32'(mats_valid), 0);
        check("t6_idle_size", size_out, 2);
        check_mats("t6_idle_mats", 2, 21, 25);
        do_start(3);
        check("t6_restart_busy", 32'(busy), 1);
        check("t6_restart_ready", 32'(in_ready), 1);
        check("t6_restart_size", size_out, 3);
        check("t6_restart_clear", 32'(|A | |B), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
